// File: rtl/frec_sel_ctrl.sv
// DPWM frequency-select sequencer: synchronises and debounces the up/down buttons,
// tracks a pending target index and commits it only on a PWM period boundary.
module frec_sel_ctrl #(
  parameter int         DB_CYCLES  = 4,
  parameter bit         WRAP       = 1'b0,
  parameter logic [2:0] FREQ_MIN   = 3'd0,
  parameter logic [2:0] FREQ_MAX   = 3'd7,
  parameter logic [2:0] RESET_FREQ = 3'd0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       boton_aumento,
  input  logic       boton_disminuye,
  input  logic       enable,
  input  logic       pwm_period_end,
  output logic [2:0] numero_frec,
  output logic [2:0] frec_target,
  output logic       busy,
  output logic       frec_changed
);

  localparam logic       IDLE    = 1'b0;
  localparam logic       ARMED   = 1'b1;
  localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

  logic [1:0]       btn_raw;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       db_q, db_d, db_dly_q, press_q;
  logic [1:0][15:0] cnt_q, cnt_d;

  logic [2:0] tgt_q, tgt_d, num_q, num_d;
  logic [2:0] up_nxt, dn_nxt;
  logic       state_q, state_d;
  logic       chg_q, chg_d;

  // Lane 0 is the up button, lane 1 the down button.
  assign btn_raw = {boton_disminuye, boton_aumento};

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          db_d[i]  = ~db_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      cnt_q    <= '0;
      db_dly_q <= '0;
      press_q  <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      cnt_q    <= cnt_d;
      db_dly_q <= db_q;
      press_q  <= db_q & ~db_dly_q;
    end
  end

  assign up_nxt = (tgt_q == FREQ_MAX) ? (WRAP ? FREQ_MIN : tgt_q) : tgt_q + 3'd1;
  assign dn_nxt = (tgt_q == FREQ_MIN) ? (WRAP ? FREQ_MAX : tgt_q) : tgt_q - 3'd1;

  // A press in the commit cycle steps from the pre-edge target, so the FSM
  // can land straight back in ARMED against the freshly committed value.
  always_comb begin
    tgt_d = tgt_q;
    num_d = num_q;
    chg_d = 1'b0;
    if (!enable) begin
      tgt_d = num_q;
    end else begin
      if (press_q == 2'b01) begin
        tgt_d = up_nxt;
      end else if (press_q == 2'b10) begin
        tgt_d = dn_nxt;
      end
      if (state_q == ARMED && pwm_period_end) begin
        num_d = tgt_q;
        chg_d = 1'b1;
      end
    end
    state_d = (tgt_d != num_d) ? ARMED : IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tgt_q   <= RESET_FREQ;
      num_q   <= RESET_FREQ;
      state_q <= IDLE;
      chg_q   <= 1'b0;
    end else begin
      tgt_q   <= tgt_d;
      num_q   <= num_d;
      state_q <= state_d;
      chg_q   <= chg_d;
    end
  end

  assign numero_frec  = num_q;
  assign frec_target  = tgt_q;
  assign busy         = (state_q == ARMED);
  assign frec_changed = chg_q;

endmodule

// File: tb/tb_frec_sel_ctrl.sv
// Directed bench for frec_sel_ctrl: a saturating and a wrapping instance share
// the same stimulus; table of button operations plus hand-timed corner sequences.
module tb_frec_sel_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btnUp, btnDn, enable, periodEnd;
  logic [2:0] numFrec, frecTarget, wNumFrec, wFrecTarget;
  logic       busy, frecChanged, wBusy, wFrecChanged;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       up;
    logic       dn;
    logic       en;
    logic       pend;
    logic [2:0] tgt;
    logic [2:0] num;
    logic       bsy;
    logic [2:0] wTgt;
    logic [2:0] wNum;
    logic       wBsy;
  } vec_t;

  vec_t vecs[12];

  frec_sel_ctrl #(.DB_CYCLES(4), .WRAP(1'b0)) dut (
    .CLK(clk), .RST(rst), .boton_aumento(btnUp), .boton_disminuye(btnDn),
    .enable(enable), .pwm_period_end(periodEnd),
    .numero_frec(numFrec), .frec_target(frecTarget), .busy(busy),
    .frec_changed(frecChanged)
  );

  frec_sel_ctrl #(.DB_CYCLES(4), .WRAP(1'b1)) dutWrap (
    .CLK(clk), .RST(rst), .boton_aumento(btnUp), .boton_disminuye(btnDn),
    .enable(enable), .pwm_period_end(periodEnd),
    .numero_frec(wNumFrec), .frec_target(wFrecTarget), .busy(wBusy),
    .frec_changed(wFrecChanged)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1; btnUp = 1'b0; btnDn = 1'b0; periodEnd = 1'b0; enable = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Hold the raw buttons long enough to debounce, then release and let it settle.
  task automatic pressOp(input logic up, input logic dn, input logic en);
    @(negedge clk);
    btnUp = up; btnDn = dn; enable = en;
    repeat (10) @(negedge clk);
    btnUp = 1'b0; btnDn = 1'b0;
    repeat (10) @(negedge clk);
    enable = 1'b1;
  endtask

  task automatic pulsePeriod();
    @(negedge clk);
    periodEnd = 1'b1;
    @(negedge clk);
    periodEnd = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.pend) pulsePeriod();
    else        pressOp(v.up, v.dn, v.en);
  endtask

  initial begin
    //            up dn en pe  tgt   num   bsy  wTgt  wNum  wBsy
    vecs[0]  = '{1, 0, 1, 0, 3'd1, 3'd0, 1, 3'd1, 3'd0, 1};
    vecs[1]  = '{0, 0, 1, 1, 3'd1, 3'd1, 0, 3'd1, 3'd1, 0};
    vecs[2]  = '{0, 1, 1, 0, 3'd0, 3'd1, 1, 3'd0, 3'd1, 1};
    vecs[3]  = '{0, 1, 1, 0, 3'd0, 3'd1, 1, 3'd7, 3'd1, 1};
    vecs[4]  = '{0, 0, 1, 1, 3'd0, 3'd0, 0, 3'd7, 3'd7, 0};
    vecs[5]  = '{0, 1, 1, 0, 3'd0, 3'd0, 0, 3'd6, 3'd7, 1};
    vecs[6]  = '{1, 0, 1, 0, 3'd1, 3'd0, 1, 3'd7, 3'd7, 0};
    vecs[7]  = '{1, 1, 1, 0, 3'd1, 3'd0, 1, 3'd7, 3'd7, 0};
    vecs[8]  = '{0, 0, 1, 1, 3'd1, 3'd1, 0, 3'd7, 3'd7, 0};
    vecs[9]  = '{1, 0, 0, 0, 3'd1, 3'd1, 0, 3'd7, 3'd7, 0};
    vecs[10] = '{1, 0, 1, 0, 3'd2, 3'd1, 1, 3'd0, 3'd7, 1};
    vecs[11] = '{0, 0, 1, 1, 3'd2, 3'd2, 0, 3'd0, 3'd0, 0};

    rst = 1'b1; btnUp = 1'b0; btnDn = 1'b0; enable = 1'b1; periodEnd = 1'b0;

    // Reset values and exact press latency.
    resetDut();
    checkOutput("reset_num", numFrec, 3'd0);
    checkOutput("reset_tgt", frecTarget, 3'd0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_chg", frecChanged, 1'b0);
    @(negedge clk);
    btnUp = 1'b1;
    repeat (7) @(negedge clk);
    checkOutput("lat_before_tgt", frecTarget, 3'd0);
    @(negedge clk);
    checkOutput("lat_at_tgt", frecTarget, 3'd1);
    checkOutput("lat_at_busy", busy, 1'b1);
    repeat (2) @(negedge clk);
    btnUp = 1'b0;
    repeat (10) @(negedge clk);
    pulsePeriod();
    checkOutput("commit_num", numFrec, 3'd1);
    checkOutput("commit_chg", frecChanged, 1'b1);
    checkOutput("commit_busy", busy, 1'b0);
    @(negedge clk);
    checkOutput("commit_chg_pulse", frecChanged, 1'b0);

    // Bouncing input never stays stable long enough.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      btnUp = ~btnUp;
    end
    @(negedge clk);
    btnUp = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("bounce_tgt", frecTarget, 3'd1);
    checkOutput("bounce_busy", busy, 1'b0);

    // Table of button/period operations.
    resetDut();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d_tgt", i), frecTarget, vecs[i].tgt);
      checkOutput($sformatf("vec%0d_num", i), numFrec, vecs[i].num);
      checkOutput($sformatf("vec%0d_busy", i), busy, vecs[i].bsy);
      checkOutput($sformatf("vec%0d_wtgt", i), wFrecTarget, vecs[i].wTgt);
      checkOutput($sformatf("vec%0d_wnum", i), wNumFrec, vecs[i].wNum);
      checkOutput($sformatf("vec%0d_wbusy", i), wBusy, vecs[i].wBsy);
    end

    // Upper limit: saturate versus wrap.
    resetDut();
    repeat (7) pressOp(1'b1, 1'b0, 1'b1);
    checkOutput("max_tgt", frecTarget, 3'd7);
    pulsePeriod();
    checkOutput("max_num", numFrec, 3'd7);
    pressOp(1'b1, 1'b0, 1'b1);
    checkOutput("sat_max_tgt", frecTarget, 3'd7);
    checkOutput("sat_max_busy", busy, 1'b0);
    checkOutput("wrap_max_tgt", wFrecTarget, 3'd0);
    checkOutput("wrap_max_busy", wBusy, 1'b1);

    // Press pulse coincident with commit, then reset while armed.
    resetDut();
    repeat (3) pressOp(1'b1, 1'b0, 1'b1);
    pulsePeriod();
    pressOp(1'b1, 1'b0, 1'b1);
    checkOutput("pre_same_num", numFrec, 3'd3);
    checkOutput("pre_same_tgt", frecTarget, 3'd4);
    @(negedge clk);
    btnUp = 1'b1;
    repeat (7) @(negedge clk);
    periodEnd = 1'b1;
    @(negedge clk);
    periodEnd = 1'b0;
    checkOutput("same_num", numFrec, 3'd4);
    checkOutput("same_tgt", frecTarget, 3'd5);
    checkOutput("same_busy", busy, 1'b1);
    checkOutput("same_chg", frecChanged, 1'b1);
    rst = 1'b1; btnUp = 1'b0;
    @(negedge clk);
    checkOutput("midrst_num", numFrec, 3'd0);
    checkOutput("midrst_tgt", frecTarget, 3'd0);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_chg", frecChanged, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Enable drop while armed aborts without committing.
    repeat (2) pressOp(1'b1, 1'b0, 1'b1);
    pulsePeriod();
    repeat (3) pressOp(1'b1, 1'b0, 1'b1);
    checkOutput("abort_pre_tgt", frecTarget, 3'd5);
    checkOutput("abort_pre_busy", busy, 1'b1);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    checkOutput("abort_tgt", frecTarget, 3'd2);
    checkOutput("abort_num", numFrec, 3'd2);
    checkOutput("abort_busy", busy, 1'b0);
    pulsePeriod();
    checkOutput("idle_pend_chg", frecChanged, 1'b0);
    checkOutput("idle_pend_num", numFrec, 3'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
